// File: rtl/mux_serial_port.sv
// Memory-mapped 8N1 console UART responder for the CPU6 bus.
// Status at BASE_ADDR, data at BASE_ADDR+1.
module mux_serial_port #(
  parameter logic [15:0] BASE_ADDR    = 16'hF200,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addressBus,
  input  logic [7:0]  dataOutBus,
  input  logic        writeEnBus,
  output logic [7:0]  dataInBus,
  output logic        selected,
  output logic        tx,
  input  logic        rx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  tx_state_t     r_tx_st, w_tx_st_n;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_n;
  logic [2:0]    r_tx_idx, w_tx_idx_n;
  logic [7:0]    r_tx_sh;
  logic [7:0]    r_hold;
  logic          r_hold_full;
  logic          w_tx_load;
  logic          w_tx_o;

  rx_state_t     r_rx_st, w_rx_st_n;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt_n;
  logic [2:0]    r_rx_idx, w_rx_idx_n;
  logic [7:0]    r_rx_sh;
  logic [7:0]    r_rx_data;
  logic          r_rx_rdy, r_ovr, r_fe;
  logic          r_rx_s1, r_rx_s2, r_rx_prev;
  logic          w_rx_shift, w_rx_good, w_rx_bad;

  logic          w_wr_stat, w_wr_data;
  logic [7:0]    w_status;

  assign selected  = (addressBus[15:1] == BASE_ADDR[15:1]);
  assign w_wr_stat = selected & writeEnBus & ~addressBus[0];
  assign w_wr_data = selected & writeEnBus & addressBus[0]
                   & ~r_hold_full;
  assign w_status  = {3'b000, (r_tx_st != TX_IDLE), r_fe,
                      r_ovr, ~r_hold_full, r_rx_rdy};
  assign tx        = w_tx_o;

  // Read mux: zero when the CPU is addressing someone else.
  always_comb begin
    dataInBus = 8'h00;
    if (selected) begin
      dataInBus = addressBus[0] ? r_rx_data : w_status;
    end
  end

  // TX next-state: one counter times every bit; holding
  // register feeds the shifter whenever it is idle or done.
  always_comb begin
    w_tx_st_n  = r_tx_st;
    w_tx_cnt_n = r_tx_cnt;
    w_tx_idx_n = r_tx_idx;
    w_tx_load  = 1'b0;
    w_tx_o     = 1'b1;
    unique case (r_tx_st)
      TX_IDLE: begin
        if (r_hold_full) begin
          w_tx_load  = 1'b1;
          w_tx_st_n  = TX_START;
          w_tx_cnt_n = '0;
        end
      end
      TX_START: begin
        w_tx_o = 1'b0;
        if (r_tx_cnt == C_LAST) begin
          w_tx_st_n  = TX_DATA;
          w_tx_cnt_n = '0;
          w_tx_idx_n = 3'd0;
        end else begin
          w_tx_cnt_n = r_tx_cnt + 1'b1;
        end
      end
      TX_DATA: begin
        w_tx_o = r_tx_sh[r_tx_idx];
        if (r_tx_cnt == C_LAST) begin
          w_tx_cnt_n = '0;
          if (r_tx_idx == 3'd7) begin
            w_tx_st_n = TX_STOP;
          end else begin
            w_tx_idx_n = r_tx_idx + 1'b1;
          end
        end else begin
          w_tx_cnt_n = r_tx_cnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (r_tx_cnt == C_LAST) begin
          w_tx_cnt_n = '0;
          if (r_hold_full) begin
            w_tx_load = 1'b1;
            w_tx_st_n = TX_START;
          end else begin
            w_tx_st_n = TX_IDLE;
          end
        end else begin
          w_tx_cnt_n = r_tx_cnt + 1'b1;
        end
      end
      default: w_tx_st_n = TX_IDLE;
    endcase
  end

  // TX registers; a write only lands while holding is empty,
  // so it never collides with a holding-to-shifter load.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx_st     <= TX_IDLE;
      r_tx_cnt    <= '0;
      r_tx_idx    <= 3'd0;
      r_tx_sh     <= 8'h00;
      r_hold      <= 8'h00;
      r_hold_full <= 1'b0;
    end else begin
      r_tx_st  <= w_tx_st_n;
      r_tx_cnt <= w_tx_cnt_n;
      r_tx_idx <= w_tx_idx_n;
      if (w_tx_load) begin
        r_tx_sh     <= r_hold;
        r_hold_full <= 1'b0;
      end else if (w_wr_data) begin
        r_hold      <= dataOutBus;
        r_hold_full <= 1'b1;
      end
    end
  end

  // rx synchronizer; left free-running through reset so only
  // a genuine falling edge after reset can start a frame.
  always_ff @(posedge clock) begin
    r_rx_s1   <= rx;
    r_rx_s2   <= r_rx_s1;
    r_rx_prev <= r_rx_s2;
  end

  // RX next-state: half-bit start check, then bit-centre
  // samples of eight data bits and the stop bit.
  always_comb begin
    w_rx_st_n  = r_rx_st;
    w_rx_cnt_n = r_rx_cnt;
    w_rx_idx_n = r_rx_idx;
    w_rx_shift = 1'b0;
    w_rx_good  = 1'b0;
    w_rx_bad   = 1'b0;
    unique case (r_rx_st)
      RX_IDLE: begin
        if (r_rx_prev & ~r_rx_s2) begin
          w_rx_st_n  = RX_START;
          w_rx_cnt_n = '0;
        end
      end
      RX_START: begin
        if (r_rx_cnt == C_HALF) begin
          w_rx_cnt_n = '0;
          w_rx_idx_n = 3'd0;
          w_rx_st_n  = r_rx_s2 ? RX_IDLE : RX_DATA;
        end else begin
          w_rx_cnt_n = r_rx_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == C_LAST) begin
          w_rx_cnt_n = '0;
          w_rx_shift = 1'b1;
          if (r_rx_idx == 3'd7) begin
            w_rx_st_n = RX_STOP;
          end else begin
            w_rx_idx_n = r_rx_idx + 1'b1;
          end
        end else begin
          w_rx_cnt_n = r_rx_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == C_LAST) begin
          w_rx_cnt_n = '0;
          w_rx_st_n  = RX_IDLE;
          w_rx_good  = r_rx_s2;
          w_rx_bad   = ~r_rx_s2;
        end else begin
          w_rx_cnt_n = r_rx_cnt + 1'b1;
        end
      end
      default: w_rx_st_n = RX_IDLE;
    endcase
  end

  // RX registers and sticky flags; a set wins over a
  // same-edge write-1-to-clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_st   <= RX_IDLE;
      r_rx_cnt  <= '0;
      r_rx_idx  <= 3'd0;
      r_rx_sh   <= 8'h00;
      r_rx_data <= 8'h00;
      r_rx_rdy  <= 1'b0;
      r_ovr     <= 1'b0;
      r_fe      <= 1'b0;
    end else begin
      r_rx_st  <= w_rx_st_n;
      r_rx_cnt <= w_rx_cnt_n;
      r_rx_idx <= w_rx_idx_n;
      if (w_rx_shift) begin
        r_rx_sh <= {r_rx_s2, r_rx_sh[7:1]};
      end
      if (w_rx_good) begin
        r_rx_data <= r_rx_sh;
      end
      r_rx_rdy <= w_rx_good
                | (r_rx_rdy & ~(w_wr_stat & dataOutBus[0]));
      r_ovr    <= (w_rx_good & r_rx_rdy)
                | (r_ovr & ~(w_wr_stat & dataOutBus[2]));
      r_fe     <= w_rx_bad
                | (r_fe & ~(w_wr_stat & dataOutBus[3]));
    end
  end

endmodule

// File: tb/tb_mux_serial_port.sv
// Directed bench for mux_serial_port: bus decode, TX framing,
// RX reception, error flags and mid-frame reset.
module tb_mux_serial_port;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addressBus = 16'hF200;
  logic [7:0]  dataOutBus = 8'h00;
  logic        writeEnBus = 1'b0;
  logic        rx = 1'b1;
  logic [7:0]  dataInBus;
  logic        selected;
  logic        tx;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] addr;
    logic        exp_sel;
    logic [7:0]  exp_dat;
  } vec_t;

  vec_t vecs[6];

  mux_serial_port #(
    .BASE_ADDR   (16'hF200),
    .CLKS_PER_BIT(16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .addressBus(addressBus),
    .dataOutBus(dataOutBus),
    .writeEnBus(writeEnBus),
    .dataInBus (dataInBus),
    .selected  (selected),
    .tx        (tx),
    .rx        (rx)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic rd_chk(input string nm,
                        input logic [15:0] a,
                        input logic [7:0] exp);
    addressBus = a;
    #1;
    chk(nm, {24'h0, dataInBus}, {24'h0, exp});
    addressBus = 16'hF200;
  endtask

  task automatic do_write(input logic [15:0] a,
                          input logic [7:0] d);
    addressBus = a;
    dataOutBus = d;
    writeEnBus = 1'b1;
    step();
    writeEnBus = 1'b0;
    addressBus = 16'hF200;
  endtask

  function automatic logic fbit(input logic [7:0] b,
                                input int k,
                                input logic stop);
    if (k == 0) return 1'b0;
    if (k >= 9) return stop;
    return b[k-1];
  endfunction

  // Write b0 at edge N (and b1/FF at N+5/N+6 when two=1),
  // then compare tx each cycle against the expected frames.
  task automatic tx_check(input logic [7:0] b0,
                          input logic [7:0] b1,
                          input bit two);
    bit e[$];
    int ncyc;
    for (int k = 0; k < 10; k++) e.push_back(fbit(b0, k, 1'b1) == 1'b1);
    if (two)
      for (int k = 0; k < 10; k++) e.push_back(fbit(b1, k, 1'b1) == 1'b1);
    ncyc = two ? 325 : 165;
    do_write(16'hF201, b0);
    for (int c = 1; c <= ncyc; c++) begin
      if (two && c == 5) begin
        addressBus = 16'hF201;
        dataOutBus = b1;
        writeEnBus = 1'b1;
      end else if (two && c == 6) begin
        addressBus = 16'hF200;
        #1;
        chk("tx_ready_low", {31'h0, dataInBus[1]}, 32'h0);
        addressBus = 16'hF201;
        dataOutBus = 8'hFF;
        writeEnBus = 1'b1;
      end else begin
        writeEnBus = 1'b0;
        addressBus = 16'hF200;
      end
      step();
      writeEnBus = 1'b0;
      for (int s = 0; s < 1; s++) begin
        bit ex;
        ex = ((c - 1) < (e.size() * 16)) ? e[(c-1)/16] : 1'b1;
        chk($sformatf("tx_c%0d", c), {31'h0, tx}, {31'h0, ex});
      end
      if (c == 80) begin
        addressBus = 16'hF200;
        #1;
        chk("tx_busy", {31'h0, dataInBus[4]}, 32'h1);
      end
    end
    rd_chk("tx_done_status", 16'hF200, 8'h02);
  endtask

  // Drive one serial frame; optionally pulse a status
  // write of 8'h01 on step clr_at.
  task automatic send_rx(input logic [7:0] b,
                         input logic stop,
                         input int clr_at);
    addressBus = 16'hF200;
    for (int t = 0; t < 160; t++) begin
      rx = fbit(b, t / 16, stop);
      if (t == clr_at) begin
        dataOutBus = 8'h01;
        writeEnBus = 1'b1;
      end
      step();
      writeEnBus = 1'b0;
    end
    rx = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    vecs[0] = '{16'hF200, 1'b1, 8'h02};
    vecs[1] = '{16'hF201, 1'b1, 8'h00};
    vecs[2] = '{16'hF202, 1'b0, 8'h00};
    vecs[3] = '{16'hF1FF, 1'b0, 8'h00};
    vecs[4] = '{16'h0200, 1'b0, 8'h00};
    vecs[5] = '{16'hF203, 1'b0, 8'h00};

    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      addressBus = vecs[i].addr;
      #1;
      chk($sformatf("sel_v%0d", i),
          {31'h0, selected}, {31'h0, vecs[i].exp_sel});
      chk($sformatf("dat_v%0d", i),
          {24'h0, dataInBus}, {24'h0, vecs[i].exp_dat});
    end
    chk("tx_idle", {31'h0, tx}, 32'h1);

    // Write to an unselected address must not start TX.
    do_write(16'hF203, 8'h00);
    repeat (3) step();
    chk("unsel_wr_tx", {31'h0, tx}, 32'h1);
    rd_chk("unsel_wr_st", 16'hF200, 8'h02);

    tx_check(8'hA5, 8'h00, 1'b0);
    tx_check(8'h55, 8'h0F, 1'b1);

    send_rx(8'h3C, 1'b1, -1);
    rd_chk("rx_good_st", 16'hF200, 8'h03);
    rd_chk("rx_good_dat", 16'hF201, 8'h3C);
    do_write(16'hF200, 8'h01);
    rd_chk("rx_clr_st", 16'hF200, 8'h02);

    // Re-arm rx_ready, then clear it on the very stop-sample
    // edge: the set wins and the old 1 flags an overrun.
    send_rx(8'h11, 1'b1, -1);
    send_rx(8'h81, 1'b1, 154);
    rd_chk("setwins_st", 16'hF200, 8'h07);
    rd_chk("setwins_dat", 16'hF201, 8'h81);
    do_write(16'hF200, 8'h05);
    rd_chk("clr2_st", 16'hF200, 8'h02);

    send_rx(8'hA1, 1'b1, -1);
    send_rx(8'h5A, 1'b1, -1);
    rd_chk("ovr_st", 16'hF200, 8'h07);
    rd_chk("ovr_dat", 16'hF201, 8'h5A);

    send_rx(8'hC3, 1'b0, -1);
    rd_chk("fe_st", 16'hF200, 8'h0F);
    rd_chk("fe_dat", 16'hF201, 8'h5A);

    rx = 1'b0;
    repeat (4) step();
    rx = 1'b1;
    repeat (20) step();
    rd_chk("glitch_st", 16'hF200, 8'h0F);
    rd_chk("glitch_dat", 16'hF201, 8'h5A);

    do_write(16'hF200, 8'h0D);
    rd_chk("clr_all_st", 16'hF200, 8'h02);

    // Reset 40 cycles into simultaneous TX and RX frames.
    for (int t = 0; t < 160; t++) begin
      rx = fbit(8'hFF, t / 16, 1'b1);
      if (t == 0) begin
        addressBus = 16'hF201;
        dataOutBus = 8'h00;
        writeEnBus = 1'b1;
      end
      if (t == 40) begin
        addressBus = 16'hF200;
        #1;
        chk("pre_rst_tx", {31'h0, tx}, 32'h0);
        reset = 1'b1;
      end
      step();
      writeEnBus = 1'b0;
      addressBus = 16'hF200;
      if (t == 40) begin
        reset = 1'b0;
        #1;
        chk("rst_tx", {31'h0, tx}, 32'h1);
        chk("rst_st", {24'h0, dataInBus}, 32'h02);
        rd_chk("rst_dat", 16'hF201, 8'h00);
      end
      if (t > 40 && tx !== 1'b1) begin
        chk($sformatf("rst_tx_hold_t%0d", t), {31'h0, tx}, 32'h1);
      end
    end
    rx = 1'b1;
    repeat (40) step();
    rd_chk("post_rst_st", 16'hF200, 8'h02);
    rd_chk("post_rst_dat", 16'hF201, 8'h00);
    chk("post_rst_tx", {31'h0, tx}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
